// File: rtl/poly_horner_eval.sv
// poly_horner_eval: streams x followed by degree+1 coefficients (highest order
// first) and evaluates the unsigned polynomial at x with Horner's rule, one
// multiply-accumulate per accepted coefficient.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous active-high reset, clears all state
//   degree       polynomial degree, sampled on the x handshake (clamped to MAX_DEGREE)
//   in_valid     in_data holds a valid word
//   in_ready     block accepts in_data this cycle (low while a result is pending)
//   in_data      x first, then the coefficients
//   out_valid    result valid, held until out_ready
//   out_ready    downstream accepts the result
//   out_data     polynomial result (wrapped or saturated)
//   out_overflow sticky: some intermediate exceeded WIDTH bits
//   busy         evaluation in progress or result pending
module poly_horner_eval #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MAX_DEGREE = 7,
  parameter int unsigned DW         = (MAX_DEGREE < 1) ? 1 : $clog2(MAX_DEGREE + 1),
  parameter bit          SATURATE   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    degree,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_overflow,
  output logic             busy
);

  // Product plus addend needs 2*WIDTH bits; one spare bit keeps the sum exact.
  localparam int unsigned FW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COEF = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [DW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [FW-1:0]    full;
  logic             step_ovf;
  logic             ovf_nxt;
  logic [WIDTH-1:0] acc_nxt;
  logic             accept;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      x_q         <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, Horner step and registered-output decode.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    x_d         = x_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    full     = FW'(acc_q) * FW'(x_q) + FW'(in_data);
    step_ovf = |full[FW-1:WIDTH];
    ovf_nxt  = ovf_q | step_ovf;
    // Once overflowed the true value only grows (x>=1), so clamping is exact.
    acc_nxt  = (SATURATE && ovf_nxt) ? {WIDTH{1'b1}} : full[WIDTH-1:0];
    accept   = in_valid && in_ready_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d     = in_data;
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = (32'(degree) > MAX_DEGREE) ? DW'(MAX_DEGREE) : degree;
          state_d = S_COEF;
        end
      end
      S_COEF: begin
        if (accept) begin
          acc_d = acc_nxt;
          ovf_d = ovf_nxt;
          if (count_q == '0) begin
            out_data_d  = acc_nxt;
            out_ovf_d   = ovf_nxt;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            count_d = count_q - DW'(1);
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d != S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_poly_horner_eval.sv
// Bench for poly_horner_eval: three instances (wrap/MAX 7, saturate/MAX 7,
// wrap/MAX 5), a polynomial reference model feeding per-instance expected
// result queues, and a negedge monitor that pops on each output handshake.
module tb_poly_horner_eval;

  logic       clk;
  logic       reset;
  logic [2:0] degree       [3];
  logic       in_valid     [3];
  logic       in_ready     [3];
  logic [7:0] in_data      [3];
  logic       out_valid    [3];
  logic       out_ready    [3];
  logic [7:0] out_data     [3];
  logic       out_overflow [3];
  logic       busy         [3];

  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic [8:0] exp_q2[$];

  int n_cmp = 0;
  int n_err = 0;

  poly_horner_eval #(.WIDTH(8), .MAX_DEGREE(7), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .degree(degree[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_overflow(out_overflow[0]), .busy(busy[0])
  );

  poly_horner_eval #(.WIDTH(8), .MAX_DEGREE(7), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .degree(degree[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_overflow(out_overflow[1]), .busy(busy[1])
  );

  poly_horner_eval #(.WIDTH(8), .MAX_DEGREE(5), .SATURATE(1'b0)) u_max5 (
    .clk(clk), .reset(reset), .degree(degree[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_overflow(out_overflow[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact Horner evaluation; overflow is judged on true values.
  function automatic logic [8:0] model(input int d, input int x, input int deg, input int c[8]);
    int         maxd = (d == 2) ? 5 : 7;
    int         n;
    logic [31:0] acc = '0;
    longint     p;
    bit         ovf = 1'b0;
    n = (deg > maxd) ? maxd : deg;
    for (int i = 0; i <= n; i++) begin
      p = longint'(acc) * longint'(x) + longint'(c[i]);
      if (p >= 256) ovf = 1'b1;
      acc = p[31:0];
    end
    if (d == 1 && ovf) return {1'b1, 8'hFF};
    return {ovf, acc[7:0]};
  endfunction

  task automatic push(input int d, input logic [8:0] v);
    case (d)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the word's handshake.
  task automatic send(input int d, input logic [7:0] w);
    int t = 0;
    in_data[d]  = w;
    in_valid[d] = 1'b1;
    while (!in_ready[d] && t < 200) begin
      cyc(1);
      t++;
    end
    if (t >= 200) chk("send_timeout", 32'(t), 32'(0));
    cyc(1);
    in_valid[d] = 1'b0;
  endtask

  task automatic eval(input int d, input int x, input int deg, input int n,
                      input int c[8], input int gap, input bit do_push);
    if (do_push) push(d, model(d, x, deg, c));
    degree[d] = 3'(deg);
    send(d, 8'(x));
    for (int i = 0; i < n; i++) begin
      send(d, 8'(c[i]));
      if (i < n - 1) cyc(gap);
    end
  endtask

  // Scoreboard: compare on every output handshake.
  always @(negedge clk) begin : mon
    logic [8:0] e;
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        if (out_valid[d] && out_ready[d]) begin
          case (d)
            0:       begin chk("q0_has_exp", 32'(exp_q0.size() > 0), 32'(1)); e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 9'h1FF; end
            1:       begin chk("q1_has_exp", 32'(exp_q1.size() > 0), 32'(1)); e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 9'h1FF; end
            default: begin chk("q2_has_exp", 32'(exp_q2.size() > 0), 32'(1)); e = (exp_q2.size() > 0) ? exp_q2.pop_front() : 9'h1FF; end
          endcase
          chk($sformatf("result_u%0d", d), 32'({out_overflow[d], out_data[d]}), 32'(e));
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      degree[d]    = '0;
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b1;
    end
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready[0]), 32'(1));
    chk("rst_busy", 32'(busy[0]), 32'(0));
    chk("rst_out_valid", 32'(out_valid[0]), 32'(0));
    chk("rst_out_data", 32'(out_data[0]), 32'(0));
    chk("rst_out_ovf", 32'(out_overflow[0]), 32'(0));

    // 1. basic x=3, 3x^2... 1*9+2*3+3 = 18
    push(0, model(0, 3, 2, '{1, 2, 3, 0, 0, 0, 0, 0}));
    degree[0] = 3'd2;
    send(0, 8'd3);
    chk("t1_busy_after_x", 32'(busy[0]), 32'(1));
    send(0, 8'd1);
    send(0, 8'd2);
    chk("t1_no_early_valid", 32'(out_valid[0]), 32'(0));
    chk("t1_busy_coef", 32'(busy[0]), 32'(1));
    send(0, 8'd3);
    chk("t1_valid_latency", 32'(out_valid[0]), 32'(1));
    chk("t1_data", 32'(out_data[0]), 32'h12);
    chk("t1_busy_done", 32'(busy[0]), 32'(1));
    chk("t1_in_ready_done", 32'(in_ready[0]), 32'(0));
    cyc(2);

    // 2. degree 0 pass-through, then test 1 with 3-cycle bubbles
    eval(0, 5, 0, 1, '{8'h2A, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b1);
    chk("t2_deg0_valid", 32'(out_valid[0]), 32'(1));
    chk("t2_deg0_data", 32'(out_data[0]), 32'h2A);
    cyc(2);
    eval(0, 3, 2, 3, '{1, 2, 3, 0, 0, 0, 0, 0}, 3, 1'b1);
    chk("t2_bubble_valid", 32'(out_valid[0]), 32'(1));
    chk("t2_bubble_data", 32'(out_data[0]), 32'h12);
    cyc(2);

    // 3. overflow in wrap and saturate modes, and x=0 with large coefficients
    eval(0, 16, 2, 3, '{1, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b1);
    chk("t3_wrap_ovf", 32'(out_overflow[0]), 32'(1));
    eval(1, 16, 2, 3, '{1, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b1);
    chk("t3_sat_data", 32'(out_data[1]), 32'hFF);
    cyc(2);
    eval(0, 0, 3, 4, '{255, 255, 255, 7, 0, 0, 0, 0}, 0, 1'b1);
    chk("t3_x0_data", 32'(out_data[0]), 32'h07);
    eval(1, 200, 4, 5, '{3, 9, 1, 0, 250, 0, 0, 0}, 1, 1'b1);
    eval(0, 200, 4, 5, '{3, 9, 1, 0, 250, 0, 0, 0}, 1, 1'b1);
    cyc(2);

    // 4. backpressure with a new x waiting on the input
    out_ready[0] = 1'b0;
    eval(0, 3, 2, 3, '{1, 2, 3, 0, 0, 0, 0, 0}, 0, 1'b1);
    push(0, model(0, 9, 1, '{1, 1, 0, 0, 0, 0, 0, 0}));
    degree[0]   = 3'd1;
    in_data[0]  = 8'd9;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(out_valid[0]), 32'(1));
      chk("t4_hold_data", 32'(out_data[0]), 32'h12);
      chk("t4_in_ready_low", 32'(in_ready[0]), 32'(0));
      cyc(1);
    end
    out_ready[0] = 1'b1;
    cyc(1);
    chk("t4_valid_drop", 32'(out_valid[0]), 32'(0));
    chk("t4_in_ready_up", 32'(in_ready[0]), 32'(1));
    chk("t4_idle_busy", 32'(busy[0]), 32'(0));
    chk("t4_data_kept", 32'(out_data[0]), 32'h12);
    cyc(1);
    in_valid[0] = 1'b0;
    chk("t4_x_taken", 32'(busy[0]), 32'(1));
    send(0, 8'd1);
    send(0, 8'd1);
    chk("t4_data_9", 32'(out_data[0]), 32'd10);
    cyc(2);

    // 5. degree clamp on the MAX_DEGREE=5 instance; 7th word is the next x
    eval(2, 2, 7, 6, '{1, 1, 1, 1, 1, 1, 0, 0}, 0, 1'b1);
    chk("t5_valid_after6", 32'(out_valid[2]), 32'(1));
    chk("t5_data", 32'(out_data[2]), 32'h3F);
    push(2, model(2, 7, 0, '{5, 0, 0, 0, 0, 0, 0, 0}));
    degree[2] = 3'd0;
    send(2, 8'd7);
    chk("t5_seventh_is_x", 32'(busy[2]), 32'(1));
    chk("t5_no_valid", 32'(out_valid[2]), 32'(0));
    send(2, 8'd5);
    chk("t5_next_data", 32'(out_data[2]), 32'd5);
    cyc(2);

    // 6. reset mid-operation, then a clean rerun
    eval(0, 3, 2, 2, '{1, 2, 0, 0, 0, 0, 0, 0}, 0, 1'b0);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t6_out_valid", 32'(out_valid[0]), 32'(0));
    chk("t6_in_ready", 32'(in_ready[0]), 32'(1));
    chk("t6_busy", 32'(busy[0]), 32'(0));
    chk("t6_out_data", 32'(out_data[0]), 32'(0));
    eval(0, 3, 2, 3, '{1, 2, 3, 0, 0, 0, 0, 0}, 0, 1'b1);
    chk("t6_rerun_data", 32'(out_data[0]), 32'h12);

    cyc(5);
    chk("q0_drained", 32'(exp_q0.size()), 32'(0));
    chk("q1_drained", 32'(exp_q1.size()), 32'(0));
    chk("q2_drained", 32'(exp_q2.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/poly_horner_eval.md
Name: poly_horner_eval

Overview:
- Parametrised successor to the fixed a·x²+b·x+c evaluator.
- Evaluates an unsigned polynomial of runtime-selectable degree (0..MAX_DEGREE) at a point x using Horner's rule, one multiply-accumulate per accepted coefficient.
- Operands stream in over a valid/ready input port; the result is returned over a valid/ready output port with an overflow flag.
- Configurable wrap or saturate arithmetic.
- Sits between a switch/key input front-end (or upstream FSM) and the result/HEX display logic.

Parameters:
- WIDTH, 8, data width of x, coefficients and result.
- MAX_DEGREE, 7, highest supported polynomial degree (>=0).
- DW, $clog2(MAX_DEGREE+1) (min 1), width of the degree port.
- SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = clamp result to all-ones on overflow.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- degree  in  DW  polynomial degree; sampled only on the x handshake.
- in_valid  in  1  in_data holds a valid word.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  WIDTH  first word = x, then degree+1 coefficients, highest order first.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  polynomial result.
- out_overflow  out  1  sticky: some intermediate exceeded WIDTH bits.
- busy  out  1  high in S_COEF and S_DONE.

Behaviour:
- Reset (synchronous, active-high, dominant over all other inputs): state=S_IDLE, acc=0, x_reg=0, count=0, ovf=0, out_valid=0, out_data=0, out_overflow=0, busy=0, in_ready=1 on the cycle after reset deasserts.
- A word is accepted when in_valid && in_ready at posedge clk.
- in_ready = 1 in S_IDLE and S_COEF; 0 in S_DONE.
- S_IDLE, on accept:
  - x_reg<=in_data; acc<=0; ovf<=0.
  - count<=min(degree, MAX_DEGREE). Degree values above MAX_DEGREE clamp.
  - Go to S_COEF.
- S_COEF, on accept:
  - full = acc*x_reg + in_data, computed at 2*WIDTH+1 bits.
  - step_ovf = (full >= 2^WIDTH).
  - Wrap mode: acc<=full[WIDTH-1:0]; ovf<=ovf|step_ovf.
  - Saturate mode: acc<=(ovf|step_ovf) ? all-ones : full[WIDTH-1:0]. This is valid because with x>=1 the true value is monotonic after overflow, and with x=0 overflow never occurs.
  - count==0: out_data<=next acc value, out_overflow<=next ovf value, out_valid<=1, go to S_DONE.
  - Otherwise count<=count-1.
- S_COEF with no accept (bubble): all registers hold. Bubbles of any length are legal.
- S_DONE: out_valid, out_data and out_overflow are stable until out_valid && out_ready. On that handshake, out_valid<=0 and the state returns to S_IDLE; the next x is accepted no earlier than the following cycle. in_valid is ignored in S_DONE.
- Latency: out_valid rises on the posedge that accepts the last coefficient, i.e. it is visible the cycle after that handshake.
- Throughput: degree+3 cycles per evaluation minimum (x, degree+1 coefficients, one output cycle).
- out_data/out_overflow keep the last result after the handshake until the next result is written; only reset clears them.
- Degree 0: the single coefficient is passed through; acc*x = 0, so overflow is impossible.
- Reset mid-operation aborts the evaluation and discards the partial accumulator; no out_valid is produced for the aborted operation.
- The multiply is a single-cycle combinational product; no pipeline registers.

Test Plan (WIDTH=8, MAX_DEGREE=7 unless noted):
1. Basic: x=3, degree=2, coefs 1,2,3 back-to-back -> out_data=0x12 (18), out_overflow=0, out_valid one cycle after the third coefficient, busy high throughout.
2. Degree 0 plus bubbles: x=5, degree=0, coef 0x2A -> 0x2A, ovf=0. Then repeat test 1 with 3 idle cycles between each coefficient -> identical 0x12 result, same cycle offset relative to the last handshake.
3. Overflow: x=16, degree=2, coefs 1,0,0. SATURATE=0 -> out_data=0x00, ovf=1. SATURATE=1 -> out_data=0xFF, ovf=1. Also x=0, degree=3, coefs 255,255,255,7 -> 0x07, ovf=0.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid while driving in_valid=1 with x=9 -> out_valid/out_data held, in_ready=0, x not captured. Raise out_ready -> handshake, in_ready=1 next cycle, x=9 accepted then.
5. Degree clamp (MAX_DEGREE=5, DW=3): degree=7, x=2, coefs 1,1,1,1,1,1 -> result=0x3F (63) after exactly 6 coefficients; a 7th word is treated as the next x.
6. Reset mid-op: x=3, degree=2, accept 2 coefs, assert reset 1 cycle -> out_valid=0, in_ready=1, busy=0, out_data=0. Rerun test 1 -> 0x12.
